ysyx_22050019_ifu: RTL and testbench

- Instruction fetch unit. Sits directly upstream of ysyx_22050019_icache and downstream of the EXU redirect path.
- Holds the PC and issues one read per instruction on the icache's valid/ready request channel (64-bit address, 64-bit data).
- Selects the 32-bit instruction from the returned doubleword and hands {inst, pc, fault} to the IDU over a valid/ready channel.
- Non-speculative, one request outstanding at a time. A redirect from the EXU kills in-flight work and restarts fetch at the new PC.

---
 rtl/ysyx_22050019_pkg.sv | 22 ++
 rtl/ysyx_22050019_ifu.sv | 165 ++++++++++++++++
 tb/tb_ysyx_22050019_ifu.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050019_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050019_pkg
// Shared definitions for the ysyx_22050019 core slice:
//   - IFU state encoding
//   - default reset PC
//   - canonical NOP instruction (addi x0, x0, 0)
//   - AXI-style OKAY response code
// ---------------------------------------------------------------------------
package ysyx_22050019_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } ifu_state_e;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [1:0]  RESP_OKAY        = 2'b00;

endpackage

// File: rtl/ysyx_22050019_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_22050019_ifu
// Instruction fetch unit. Holds the PC, issues one icache read per
// instruction, selects the 32-bit word from the returned doubleword and
// hands {inst, pc, fault} to the IDU. One request outstanding at a time;
// an EXU redirect kills in-flight work and restarts fetch at the new PC.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   redirect_valid_i    EXU redirect strobe (highest priority)
//   redirect_pc_i       redirect target (low two bits ignored)
//   ar_valid_o/ready_i  fetch request handshake, ar_addr_o = current PC
//   r_valid_i/ready_o   read data handshake, r_resp_i (!=0 -> error), r_data_i
//   inst_valid_o/ready_i  instruction handshake to IDU
//   inst_o, inst_pc_o, inst_fault_o  instruction payload
//
// Handshake semantics (all three channels): a transfer happens on a rising
// clk edge where valid and ready are both high. A producer never lowers
// valid or changes its payload before the transfer, except that a redirect
// may move ar_addr_o while ar_valid_o is held and may drop inst_valid_o
// combinationally (the instruction is being killed).
// ---------------------------------------------------------------------------
module ysyx_22050019_ifu
    import ysyx_22050019_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  ar_valid_o,
    input  logic                  ar_ready_i,
    output logic [ADDR_WIDTH-1:0] ar_addr_o,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,
    input  logic [1:0]            r_resp_i,
    input  logic [DATA_WIDTH-1:0] r_data_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic                  inst_fault_o
);

    ifu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  drop_q, drop_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                  fault_q, fault_d;

    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [INST_WIDTH-1:0] sel_inst;

    // Instructions are 4-byte aligned; masking keeps every bit of the
    // redirect bus in use.
    assign redirect_target = redirect_pc_i & ~ADDR_WIDTH'(3);

    // Pick the word addressed by pc[2]; an error response substitutes a NOP
    // so that the IDU always sees a harmless encoding alongside the fault.
    always_comb begin
        sel_inst = pc_q[2] ? r_data_i[2*INST_WIDTH-1:INST_WIDTH]
                           : r_data_i[INST_WIDTH-1:0];
        if (r_resp_i != RESP_OKAY) begin
            sel_inst = NOP_INST;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        ar_valid_o   = 1'b0;
        r_ready_o    = 1'b0;
        inst_valid_o = 1'b0;
        case (state_q)
            S_REQ:   ar_valid_o   = 1'b1;
            S_WAIT:  r_ready_o    = 1'b1;
            S_OUT:   inst_valid_o = ~redirect_valid_i;
            default: ;
        endcase
    end

    assign ar_addr_o    = pc_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_fault_o = fault_q;

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;

        case (state_q)
            S_IDLE: state_d = S_REQ;

            S_REQ: begin
                if (ar_ready_i) begin
                    state_d = S_WAIT;
                    // Request already accepted for the old PC: its data
                    // must be thrown away when it arrives.
                    if (redirect_valid_i) begin
                        drop_d = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (r_valid_i) begin
                    if (drop_q || redirect_valid_i) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d    = sel_inst;
                        inst_pc_d = pc_q;
                        fault_d   = |r_resp_i;
                        state_d   = S_OUT;
                    end
                end else if (redirect_valid_i) begin
                    drop_d = 1'b1;
                end
            end

            S_OUT: begin
                if (redirect_valid_i) begin
                    state_d = S_REQ;
                end else if (inst_ready_i) begin
                    pc_d    = pc_q + ADDR_WIDTH'(4);
                    state_d = S_REQ;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (redirect_valid_i) begin
            pc_d = redirect_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050019_ifu
// Bench for the instruction fetch unit. The bench plays both the icache and
// the IDU. Expected {fault, pc, inst} records are queued when a request is
// accepted and popped when the IDU takes an instruction.
// ---------------------------------------------------------------------------
module tb_ysyx_22050019_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid_i;
    logic [63:0] redirect_pc_i;
    logic        ar_valid_o;
    logic        ar_ready_i;
    logic [63:0] ar_addr_o;
    logic        r_valid_i;
    logic        r_ready_o;
    logic [1:0]  r_resp_i;
    logic [63:0] r_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [63:0] inst_pc_o;
    logic        inst_fault_o;

    int n_vec = 0;
    int n_err = 0;
    logic [96:0] exp_q[$];

    typedef struct {
        logic [63:0] pc;
        logic [63:0] data;
        logic [1:0]  resp;
        int          lat;
        int          stall;
        logic [31:0] exp_inst;
        logic        exp_fault;
    } vec_t;

    ysyx_22050019_ifu dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .ar_valid_o       (ar_valid_o),
        .ar_ready_i       (ar_ready_i),
        .ar_addr_o        (ar_addr_o),
        .r_valid_i        (r_valid_i),
        .r_ready_o        (r_ready_o),
        .r_resp_i         (r_resp_i),
        .r_data_i         (r_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .inst_fault_o     (inst_fault_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Waits (bounded) for a negedge where ar_valid_o is high. Releases the
    // IDU ready at every negedge so a previous handshake is not repeated.
    task automatic wait_ar(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            inst_ready_i = 1'b0;
            if (ar_valid_o === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        check("ar_valid_timeout", 64'(ar_valid_o), 64'd1);
    endtask

    // One full fetch: accept request, answer after lat cycles, hold the IDU
    // off for stall cycles, then take the instruction.
    task automatic fetch_one(input logic [63:0] pc, input logic [63:0] data,
                             input logic [1:0] resp, input logic [31:0] ei,
                             input logic fi, input int lat, input int stall,
                             output time hs_t);
        bit          ok;
        logic [96:0] snap;
        logic [96:0] e;
        hs_t = 0;
        wait_ar(ok);
        if (!ok) return;
        check("ar_addr", ar_addr_o, pc);
        ar_ready_i = 1'b1;
        exp_q.push_back({fi, pc, ei});
        @(negedge clk);
        ar_ready_i = 1'b0;
        check("ar_valid_after_hs", 64'(ar_valid_o), 64'd0);
        for (int i = 1; i < lat; i++) @(negedge clk);
        check("r_ready", 64'(r_ready_o), 64'd1);
        r_valid_i = 1'b1;
        r_data_i  = data;
        r_resp_i  = resp;
        @(negedge clk);
        r_valid_i = 1'b0;
        r_data_i  = {$urandom, $urandom};
        r_resp_i  = 2'b00;
        check("inst_valid", 64'(inst_valid_o), 64'd1);
        snap = {inst_fault_o, inst_pc_o, inst_o};
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_stable", snap[63:0], {inst_pc_o[31:0], inst_o});
            check("hold_pc_hi", 64'(snap[96:64]), 64'({inst_fault_o, inst_pc_o[63:32]}));
            check("hold_valid", 64'(inst_valid_o), 64'd1);
            check("hold_no_ar", 64'(ar_valid_o), 64'd0);
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check("idu_inst",  64'(inst_o), 64'(e[31:0]));
            check("idu_pc",    inst_pc_o, e[95:32]);
            check("idu_fault", 64'(inst_fault_o), 64'(e[96]));
        end
        inst_ready_i = 1'b1;
        @(posedge clk);
        hs_t = $time;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t        tbl[8];
        time         t0, t1, tdummy;
        bit          ok;
        logic [63:0] rp, rdata;
        logic [1:0]  rresp;
        logic [31:0] rinst;

        tbl[0] = '{64'h8000_0000, 64'h0010_0093_0000_0013, 2'b00, 2, 0, 32'h0000_0013, 1'b0};
        tbl[1] = '{64'h8000_0004, 64'h0010_0093_0000_0013, 2'b00, 2, 0, 32'h0010_0093, 1'b0};
        tbl[2] = '{64'h8000_0008, 64'hAAAA_BBBB_1234_5678, 2'b00, 2, 5, 32'h1234_5678, 1'b0};
        tbl[3] = '{64'h8000_000C, 64'h00A0_0513_FFFF_FFFF, 2'b00, 1, 1, 32'h00A0_0513, 1'b0};
        tbl[4] = '{64'h8000_0010, 64'h0000_0073_0000_0073, 2'b10, 2, 0, 32'h0000_0013, 1'b1};
        tbl[5] = '{64'h8000_0014, 64'hDEAD_BEEF_0000_0000, 2'b00, 3, 0, 32'hDEAD_BEEF, 1'b0};
        tbl[6] = '{64'h8000_0018, 64'h1122_3344_5566_7788, 2'b01, 1, 2, 32'h0000_0013, 1'b1};
        tbl[7] = '{64'h8000_001C, 64'h1122_3344_5566_7788, 2'b00, 4, 0, 32'h1122_3344, 1'b0};

        rst = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i = '0;
        ar_ready_i = 1'b0;
        r_valid_i = 1'b0;
        r_resp_i = 2'b00;
        r_data_i = '0;
        inst_ready_i = 1'b0;
        t0 = 0;
        t1 = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ar_valid",   64'(ar_valid_o), 64'd0);
        check("rst_r_ready",    64'(r_ready_o), 64'd0);
        check("rst_inst_valid", 64'(inst_valid_o), 64'd0);
        check("rst_inst",       64'(inst_o), 64'd0);
        check("rst_inst_pc",    inst_pc_o, 64'd0);
        check("rst_fault",      64'(inst_fault_o), 64'd0);
        check("rst_ar_addr",    ar_addr_o, 64'h8000_0000);
        rst = 1'b0;

        // Table-driven sequential fetches.
        for (int i = 0; i < 8; i++) begin
            fetch_one(tbl[i].pc, tbl[i].data, tbl[i].resp, tbl[i].exp_inst,
                      tbl[i].exp_fault, tbl[i].lat, tbl[i].stall, tdummy);
            if (i == 0) t0 = tdummy;
            if (i == 1) t1 = tdummy;
        end
        // Latency 2 with IDU always ready: one instruction every 4 cycles.
        check("throughput", 64'(t1 - t0), 64'd40);

        // Redirect while waiting for data; response arrives later and is dropped.
        wait_ar(ok);
        check("redir_wait_addr", ar_addr_o, 64'h8000_0020);
        ar_ready_i = 1'b1;
        @(negedge clk);
        ar_ready_i = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 64'h8000_0102;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        check("redir_wait_noinst0", 64'(inst_valid_o), 64'd0);
        @(negedge clk);
        check("redir_wait_noinst1", 64'(inst_valid_o), 64'd0);
        r_valid_i = 1'b1;
        r_data_i = 64'h1111_1111_2222_2222;
        @(negedge clk);
        r_valid_i = 1'b0;
        check("redir_wait_noinst2", 64'(inst_valid_o), 64'd0);
        check("redir_wait_req",     64'(ar_valid_o), 64'd1);
        check("redir_wait_newpc",   ar_addr_o, 64'h8000_0100);
        fetch_one(64'h8000_0100, 64'h0000_0000_0040_0113, 2'b00, 32'h0040_0113, 1'b0, 2, 0, tdummy);

        // Redirect in the same cycle as the ar handshake.
        wait_ar(ok);
        ar_ready_i = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 64'h8000_0200;
        @(negedge clk);
        ar_ready_i = 1'b0;
        redirect_valid_i = 1'b0;
        check("redir_hs_wait", 64'(r_ready_o), 64'd1);
        r_valid_i = 1'b1;
        @(negedge clk);
        r_valid_i = 1'b0;
        check("redir_hs_noinst", 64'(inst_valid_o), 64'd0);
        check("redir_hs_req",    64'(ar_valid_o), 64'd1);
        check("redir_hs_newpc",  ar_addr_o, 64'h8000_0200);

        // Redirect in the same cycle as r_valid_i.
        wait_ar(ok);
        ar_ready_i = 1'b1;
        @(negedge clk);
        ar_ready_i = 1'b0;
        r_valid_i = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 64'h8000_0304;
        @(negedge clk);
        r_valid_i = 1'b0;
        redirect_valid_i = 1'b0;
        check("redir_r_noinst", 64'(inst_valid_o), 64'd0);
        check("redir_r_newpc",  ar_addr_o, 64'h8000_0304);
        fetch_one(64'h8000_0304, 64'h0000_0517_FFFF_0000, 2'b00, 32'h0000_0517, 1'b0, 1, 0, tdummy);

        // Redirect in S_REQ without handshake, to the top of the address space.
        wait_ar(ok);
        redirect_valid_i = 1'b1;
        redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        check("redir_req_valid", 64'(ar_valid_o), 64'd1);
        check("redir_req_addr",  ar_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch_one(64'hFFFF_FFFF_FFFF_FFFC, 64'hCAFE_0001_0000_0000, 2'b00, 32'hCAFE_0001, 1'b0, 2, 0, tdummy);
        fetch_one(64'h0000_0000_0000_0000, 64'h0000_0000_0BAD_F00D, 2'b00, 32'h0BAD_F00D, 1'b0, 2, 0, tdummy);

        // Kill in S_OUT even with inst_ready_i high.
        wait_ar(ok);
        ar_ready_i = 1'b1;
        @(negedge clk);
        ar_ready_i = 1'b0;
        r_valid_i = 1'b1;
        r_data_i = 64'h7777_7777_6666_6666;
        @(negedge clk);
        r_valid_i = 1'b0;
        check("kill_pre_valid", 64'(inst_valid_o), 64'd1);
        inst_ready_i = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 64'h8000_0400;
        #1;
        check("kill_comb_valid", 64'(inst_valid_o), 64'd0);
        @(negedge clk);
        inst_ready_i = 1'b0;
        redirect_valid_i = 1'b0;
        check("kill_post_valid", 64'(inst_valid_o), 64'd0);
        check("kill_req",        64'(ar_valid_o), 64'd1);
        check("kill_newpc",      ar_addr_o, 64'h8000_0400);

        // Random sequential fetches.
        rp = 64'h8000_0400;
        for (int i = 0; i < 8; i++) begin
            rdata = {$urandom, $urandom};
            rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rinst = (rresp != 2'b00) ? 32'h0000_0013 : (rp[2] ? rdata[63:32] : rdata[31:0]);
            fetch_one(rp, rdata, rresp, rinst, |rresp,
                      $urandom_range(1, 4), $urandom_range(0, 2), tdummy);
            rp = rp + 64'd4;
        end

        // Reset while waiting for read data.
        wait_ar(ok);
        ar_ready_i = 1'b1;
        @(negedge clk);
        ar_ready_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst2_ar_valid",   64'(ar_valid_o), 64'd0);
        check("rst2_r_ready",    64'(r_ready_o), 64'd0);
        check("rst2_inst_valid", 64'(inst_valid_o), 64'd0);
        check("rst2_inst",       64'(inst_o), 64'd0);
        check("rst2_inst_pc",    inst_pc_o, 64'd0);
        check("rst2_fault",      64'(inst_fault_o), 64'd0);
        check("rst2_ar_addr",    ar_addr_o, 64'h8000_0000);
        rst = 1'b0;
        fetch_one(64'h8000_0000, 64'h0010_0093_0000_0013, 2'b00, 32'h0000_0013, 1'b0, 2, 0, tdummy);

        @(negedge clk);
        inst_ready_i = 1'b0;
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

endmodule
